// File: rtl/axil_io_regs.sv
// AXI4-Lite register bank for the board I/O: LEDs, seven-segment, PMOD JA,
// switch/PMOD readback and a scratch/ID pair. Read and write channels run independently.
module axil_io_regs #(
    parameter logic [31:0] ID_VALUE = 32'h42A5_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  control_awaddr,
    input  logic        control_awvalid,
    output logic        control_awready,
    input  logic [31:0] control_wdata,
    input  logic        control_wvalid,
    output logic        control_wready,
    output logic [1:0]  control_bresp,
    output logic        control_bvalid,
    input  logic        control_bready,
    input  logic [7:0]  control_araddr,
    input  logic        control_arvalid,
    output logic        control_arready,
    output logic [31:0] control_rdata,
    output logic [1:0]  control_rresp,
    output logic        control_rvalid,
    input  logic        control_rready,
    input  logic [15:0] sw,
    input  logic [7:0]  ja_in,
    output logic [15:0] led,
    output logic [15:0] seg_digits,
    output logic        seg_en,
    output logic [3:0]  seg_dp,
    output logic [7:0]  ja_out,
    output logic [7:0]  ja_tri
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [5:0] LAST_IDX    = 6'd8;

    // Every channel transfers on a rising edge where valid and ready are both high;
    // a source keeps valid and its payload steady until that edge, ready may change freely.

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

    rd_state_t rd_state, rd_next;

    logic [15:0] sw_s1, sw_s2;
    logic [7:0]  ja_s1, ja_s2;
    logic [31:0] scratch;

    logic        aw_held, w_held;
    logic [5:0]  aw_idx_q;
    logic [31:0] w_data_q;
    logic        aw_hs, w_hs, commit;
    logic [5:0]  wr_idx;
    logic [31:0] wr_data;

    logic        ar_hs;
    logic [5:0]  rd_idx;
    logic [31:0] rd_word;
    logic [1:0]  rd_resp;

    // Byte-lane bits of the addresses carry no meaning for full-word registers.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{control_awaddr[1:0], control_araddr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            ja_s1 <= '0;
            ja_s2 <= '0;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;
            ja_s1 <= ja_in;
            ja_s2 <= ja_s1;
        end
    end

    assign control_awready = !aw_held && !control_bvalid && !reset;
    assign control_wready  = !w_held && !control_bvalid && !reset;
    assign aw_hs   = control_awvalid && control_awready;
    assign w_hs    = control_wvalid && control_wready;
    assign commit  = (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_idx  = aw_held ? aw_idx_q : control_awaddr[7:2];
    assign wr_data = w_held ? w_data_q : control_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx_q <= '0;
            w_data_q <= '0;
        end else begin
            if (aw_hs) aw_idx_q <= control_awaddr[7:2];
            if (w_hs)  w_data_q <= control_wdata;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end else begin
                if (aw_hs) aw_held <= 1'b1;
                if (w_hs)  w_held  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            control_bvalid <= 1'b0;
            control_bresp  <= RESP_OKAY;
        end else if (commit) begin
            control_bvalid <= 1'b1;
            control_bresp  <= (wr_idx > LAST_IDX) ? RESP_SLVERR : RESP_OKAY;
        end else if (control_bready) begin
            control_bvalid <= 1'b0;
        end
    end

    // Read-only and out-of-range offsets fall through the case untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led        <= '0;
            seg_digits <= '0;
            seg_en     <= 1'b0;
            seg_dp     <= '0;
            ja_out     <= '0;
            ja_tri     <= 8'hFF;
            scratch    <= '0;
        end else if (commit) begin
            case (wr_idx)
                6'd0: led <= wr_data[15:0];
                6'd2: seg_digits <= wr_data[15:0];
                6'd3: begin
                    seg_en <= wr_data[0];
                    seg_dp <= wr_data[7:4];
                end
                6'd4: ja_out  <= wr_data[7:0];
                6'd5: ja_tri  <= wr_data[7:0];
                6'd7: scratch <= wr_data;
                default: ;
            endcase
        end
    end

    assign rd_idx = control_araddr[7:2];

    always_comb begin
        rd_word = '0;
        rd_resp = RESP_OKAY;
        case (rd_idx)
            6'd0: rd_word = {16'h0, led};
            6'd1: rd_word = {16'h0, sw_s2};
            6'd2: rd_word = {16'h0, seg_digits};
            6'd3: rd_word = {24'h0, seg_dp, 3'b000, seg_en};
            6'd4: rd_word = {24'h0, ja_out};
            6'd5: rd_word = {24'h0, ja_tri};
            6'd6: rd_word = {24'h0, ja_s2};
            6'd7: rd_word = scratch;
            6'd8: rd_word = ID_VALUE;
            default: rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_state <= RD_IDLE;
        else       rd_state <= rd_next;
    end

    always_comb begin
        rd_next         = rd_state;
        control_arready = 1'b0;
        control_rvalid  = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                control_arready = !reset;
                if (control_arvalid && !reset) rd_next = RD_RESP;
            end
            RD_RESP: begin
                control_rvalid = 1'b1;
                if (control_rready) rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    assign ar_hs = control_arvalid && control_arready;

    // Captured at the AR edge from pre-write register values, held while rvalid is up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            control_rdata <= '0;
            control_rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            control_rdata <= rd_word;
            control_rresp <= rd_resp;
        end
    end

endmodule
